// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the comparator test-pulser mux scan sequencer.
// State encodings are plain constants so they can be reused by older benches.
package mux_scan_sequencer_pkg;

  localparam int ADR_W  = 4;
  localparam int NUM_CH = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETTLE = 3'd1;
  localparam state_t ST_ENABLE = 3'd2;
  localparam state_t ST_GAP    = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/mux_scan_sequencer_triad.sv
// Centre channel to high/med/low pulse-mux address triad, wrapping modulo 16.
// Purely combinational so the protection-stage bench can reuse it.
module mux_triad_addr
  import mux_scan_sequencer_pkg::*;
(
  input  logic [ADR_W-1:0] centre,
  output logic [ADR_W-1:0] high,
  output logic [ADR_W-1:0] med,
  output logic [ADR_W-1:0] low
);

  // Native ADR_W-bit arithmetic provides the wrap (15+1 -> 0, 0-1 -> 15).
  assign high = centre + ADR_W'(1);
  assign med  = centre;
  assign low  = centre - ADR_W'(1);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans a centre channel across a captured range, issuing settle/enable/gap
// timed test pulses, and drives the raw mux enable and address triad.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int EN_CYCLES     = 16,
  parameter int GAP_CYCLES    = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       ch_first,
  input  logic [3:0]       ch_last,
  input  logic [CNT_W-1:0] pulses_per_ch,
  output logic [3:0]       high_adr_out,
  output logic [3:0]       med_adr_out,
  output logic [3:0]       low_adr_out,
  output logic             mux_en_out,
  output logic             pulse_trig,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LD     = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] tmr, tmr_nx;
  logic [CNT_W-1:0] pcnt, pcnt_nx;
  logic [CNT_W-1:0] p_cap, p_cap_nx;
  logic [ADR_W-1:0] centre, centre_nx;
  logic [ADR_W-1:0] last_q, last_nx;
  logic [ADR_W-1:0] tri_high, tri_med, tri_low;

  // Triad is computed from the next centre so the address outputs are registers.
  mux_triad_addr u_triad (
    .centre (centre_nx),
    .high   (tri_high),
    .med    (tri_med),
    .low    (tri_low)
  );

  always_comb begin
    state_nx  = state;
    tmr_nx    = tmr;
    pcnt_nx   = pcnt;
    p_cap_nx  = p_cap;
    centre_nx = centre;
    last_nx   = last_q;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nx  = ST_SETTLE;
          tmr_nx    = SETTLE_LD;
          centre_nx = ch_first;
          last_nx   = ch_last;
          p_cap_nx  = (pulses_per_ch == '0) ? CNT_W'(1) : pulses_per_ch;
          pcnt_nx   = (pulses_per_ch == '0) ? CNT_W'(1) : pulses_per_ch;
        end
      end
      ST_SETTLE: begin
        if (tmr == '0) begin
          state_nx = ST_ENABLE;
          tmr_nx   = EN_LD;
        end else begin
          tmr_nx = tmr - CNT_W'(1);
        end
      end
      ST_ENABLE: begin
        if (tmr == '0) begin
          state_nx = ST_GAP;
          tmr_nx   = GAP_LD;
        end else begin
          tmr_nx = tmr - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (tmr != '0) begin
          tmr_nx = tmr - CNT_W'(1);
        end else if (pcnt > CNT_W'(1)) begin
          // pcnt counts pulses still owed on this channel, including the one just issued.
          state_nx = ST_ENABLE;
          tmr_nx   = EN_LD;
          pcnt_nx  = pcnt - CNT_W'(1);
        end else if (centre != last_q) begin
          state_nx  = ST_SETTLE;
          tmr_nx    = SETTLE_LD;
          centre_nx = centre + ADR_W'(1);
          pcnt_nx   = p_cap;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    // Abort overrides everything outside IDLE; addresses hold where they are.
    if (abort && state != ST_IDLE) begin
      state_nx  = ST_IDLE;
      centre_nx = centre;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      tmr          <= '0;
      pcnt         <= '0;
      p_cap        <= '0;
      centre       <= '0;
      last_q       <= '0;
      high_adr_out <= 4'd1;
      med_adr_out  <= 4'd0;
      low_adr_out  <= 4'd15;
      mux_en_out   <= 1'b0;
      pulse_trig   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nx;
      tmr          <= tmr_nx;
      pcnt         <= pcnt_nx;
      p_cap        <= p_cap_nx;
      centre       <= centre_nx;
      last_q       <= last_nx;
      high_adr_out <= tri_high;
      med_adr_out  <= tri_med;
      low_adr_out  <= tri_low;
      mux_en_out   <= (state_nx == ST_ENABLE);
      pulse_trig   <= (state_nx == ST_ENABLE) && (state != ST_ENABLE);
      busy         <= (state_nx != ST_IDLE);
      done         <= (state_nx == ST_DONE);
    end
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Generates the high/med/low pulse-mux address triad and the raw mux enable for the comparator test pulser.
- Scans a centre channel across a programmable range, issuing N test pulses per channel with settle, enable and gap timing.
- Outputs feed the mux-conflict protection stage directly; that stage adds one register of latency on the enable.

Parameters:
SETTLE_CYCLES, 8, cycles addresses are held with enable low before the first pulse on a channel (>=1)
EN_CYCLES, 16, cycles mux_en_out is high per pulse (>=1)
GAP_CYCLES, 4, cycles enable is low after each pulse (>=1)
CNT_W, 8, width of the timing and pulse counters

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  begin scan; sampled only in IDLE
abort  in  1  terminate scan immediately
ch_first  in  4  first centre channel
ch_last  in  4  last centre channel
pulses_per_ch  in  CNT_W  pulses per channel; 0 is treated as 1
high_adr_out  out  4  centre+1 mod 16
med_adr_out  out  4  centre channel
low_adr_out  out  4  centre-1 mod 16
mux_en_out  out  1  raw mux enable, to the protection stage
pulse_trig  out  1  one-cycle strobe on the first cycle of each enable
busy  out  1  high in every state except IDLE
done  out  1  one-cycle strobe at normal scan completion

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-low (reset_n sampled on the rising edge of clock).
- Reset values: state IDLE; med=0, high=1, low=15; mux_en_out, pulse_trig, busy and done all 0.
- All outputs are registered.
- State machine: IDLE, SETTLE, ENABLE, GAP, DONE.
- IDLE:
  - start=1 at edge k: at k+1 the state is SETTLE, busy=1, and med=ch_first with high/low derived from it.
  - Pulse counter is loaded with max(pulses_per_ch,1).
- SETTLE: lasts exactly SETTLE_CYCLES cycles, then ENABLE.
- ENABLE:
  - mux_en_out=1 for exactly EN_CYCLES cycles.
  - pulse_trig=1 on the first ENABLE cycle only.
  - Then GAP.
- GAP: lasts exactly GAP_CYCLES cycles, then:
  - if pulses remain on this channel: ENABLE (no re-settle);
  - else if centre != ch_last: centre = centre+1 mod 16, reload pulse counter, SETTLE;
  - else DONE.
- DONE: one cycle with done=1 and busy=1, then IDLE; busy=0 from the first IDLE cycle.
- Addresses change only on the transition into SETTLE, so they never change while mux_en_out=1. They hold their last value in IDLE.
- Range and wrap:
  - ch_first>ch_last scans upward with wrap (e.g. 14,15,0,1).
  - ch_first==ch_last scans one channel.
  - high/low wrap modulo 16 (centre 15 gives high=0; centre 0 gives low=15).
  - The three addresses are therefore always distinct.
- Input capture: ch_first, ch_last and pulses_per_ch are captured at start; later changes do not affect a scan in progress.
- start while busy: ignored.
- start and abort in the same IDLE cycle: abort wins; the block stays IDLE.
- abort in any non-IDLE state:
  - next cycle IDLE, mux_en_out=0, pulse_trig=0, busy=0;
  - done is not asserted;
  - addresses hold.
- reset_n low mid-scan: all outputs return to reset values on the next edge.
- Timing per channel: SETTLE_CYCLES + P*(EN_CYCLES+GAP_CYCLES) cycles, where P=max(pulses_per_ch,1).
- Total scan: channels*that + 1 (DONE) cycles from the first SETTLE cycle.

Decomposition:
- Shared package: state enum (IDLE/SETTLE/ENABLE/GAP/DONE), ADR_W=4, NUM_CH=16.
- One natural sub-module, mux_triad_addr: combinational centre -> {high,med,low} with mod-16 wrap. Reusable by the protection-stage bench.
- Timing counter and FSM stay in the top module.

Test Plan:
- Single channel, defaults, ch_first=ch_last=5, pulses=1, start at cycle 0:
  - med=5, high=6, low=4 from cycle 1;
  - mux_en_out high cycles 9..24, pulse_trig at 9;
  - GAP 25..28, done at 29, busy=0 at 30.
- Wrap scan, ch_first=14, ch_last=1, pulses=2:
  - centres 14,15,0,1 in order; triads (15,14,13), (0,15,14), (1,0,15), (2,1,0);
  - 8 pulse_trig strobes; no address change while mux_en_out=1.
- pulses_per_ch=0, ch 3..3:
  - exactly one pulse and one done strobe.
- Abort on the 5th ENABLE cycle:
  - next cycle mux_en_out=0, busy=0, no done;
  - a new start afterwards runs a full scan normally.
- start pulsed mid-scan, and ch_last changed mid-scan:
  - no effect; the original range completes.
- reset_n=0 during GAP:
  - next edge outputs are med=0, high=1, low=15, all strobes 0, state IDLE.
